// File: rtl/conv_kxk_layer.sv
// conv_kxk_layer: convolution-layer engine for one KxK layer.
// It reads a KxK kernel from SDRAM once, then slides a KxK window over an
// IMG_H x IMG_W feature map and writes one output word per window position.
// Every access goes through a single Wishbone master port and only one
// transaction is outstanding at a time.
// Each output is computed by a sequential signed multiply-accumulate. The sum
// is then shifted to the fixed-point scale, saturated to 16 bits and passed
// through an optional ReLU.

module conv_kxk_layer #(
   parameter int IMG_W       = 10,
   parameter int IMG_H       = 10,
   parameter int K           = 3,
   parameter int KERNEL_BASE = 0,
   parameter int IMG_BASE    = 18,
   parameter int OUT_BASE    = 118,
   parameter int ACC_W       = 40,
   parameter int FRAC        = 8
) (
   input  logic        CLK,
   input  logic        rst,
   input  logic        start,
   input  logic        relu_en,
   output logic        busy,
   output logic        done,
   output logic        sat_flag,
   input  logic [31:0] data_o,
   input  logic        stall_o,
   input  logic        sdram_ack,
   output logic        stb_i,
   output logic        we_i,
   output logic [3:0]  sel_i,
   output logic        cyc_i,
   output logic [31:0] addr_i,
   output logic [31:0] data_i
);

   localparam int OW = IMG_W - K + 1;
   localparam int OH = IMG_H - K + 1;
   localparam int KK = K * K;
   localparam int EW = $clog2(KK);

   // Saturation limits, sign-extended to accumulator width.
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-16){1'b0}}, 16'h7FFF};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-16){1'b1}}, 16'h8000};

   typedef enum logic [2:0] {
      IDLE,
      LD_KERNEL,
      RD_PIX,
      WR_OUT,
      FINISH
   } state_t;

   state_t                   state;
   logic                     relu_q;
   logic [EW-1:0]            eidx;    // element index inside kernel / window
   logic [15:0]              ki, kj;  // window row / column of current element
   logic [15:0]              oi, oj;  // output row / column
   logic signed [ACC_W-1:0]  acc;
   logic signed [15:0]       kern [KK];

   // Combinational helpers.
   logic                     xfer_done;
   logic                     e_last, kj_last, oj_last, oi_last;
   logic [15:0]              kj_nx, ki_nx, oj_nx, oi_nx;
   logic [31:0]              kaddr_nx, pix_addr_nx, win_addr, out_addr;
   logic signed [31:0]       pix32, k32, prod;
   logic signed [ACC_W-1:0]  acc_sum, shifted;
   logic signed [15:0]       res;
   logic                     clip;
   logic                     unused_hi;

   // The upper half of the read bus carries nothing for this engine.
   assign unused_hi = ^data_o[31:16];

   // Word address of image pixel (r, c), row-major.
   function automatic logic [31:0] pix_addr(input logic [15:0] r, input logic [15:0] c);
      return 32'(IMG_BASE) + 32'(r) * 32'(IMG_W) + 32'(c);
   endfunction

   // Access completion: an ack counts only while a cycle is open, and not while
   // the request is still being held off by stall.
   always_comb begin
      xfer_done = cyc_i && sdram_ack && (!stb_i || !stall_o);
   end

   // Next-element / next-window counters and the addresses they select.
   always_comb begin
      e_last      = (eidx == EW'(KK - 1));
      kj_last     = (kj == 16'(K - 1));
      oj_last     = (oj == 16'(OW - 1));
      oi_last     = (oi == 16'(OH - 1));
      kj_nx       = kj_last ? 16'd0 : kj + 16'd1;
      ki_nx       = kj_last ? ki + 16'd1 : ki;
      oj_nx       = oj_last ? 16'd0 : oj + 16'd1;
      oi_nx       = oj_last ? oi + 16'd1 : oi;
      kaddr_nx    = 32'(KERNEL_BASE) + 32'(eidx) + 32'd1;
      pix_addr_nx = pix_addr(oi + ki_nx, oj + kj_nx);
      win_addr    = pix_addr(oi_nx, oj_nx);
      out_addr    = 32'(OUT_BASE) + 32'(oi) * 32'(OW) + 32'(oj);
   end

   // MAC datapath and output conditioning (shift, saturate, ReLU).
   // The result is ready in the same cycle as the last pixel ack, so the write
   // can be issued on the very next cycle.
   always_comb begin
      // NOTE: every variable gets a value before any branch, so no path through this block can leave one unassigned and infer a latch.
      clip    = 1'b0;
      pix32   = {{16{data_o[15]}}, data_o[15:0]};
      k32     = {{16{kern[eidx][15]}}, kern[eidx]};
      prod    = pix32 * k32;
      acc_sum = acc + {{(ACC_W-32){prod[31]}}, prod};
      shifted = acc_sum >>> FRAC;
      res     = shifted[15:0];
      if (shifted > SAT_MAX) begin
         res  = 16'sh7FFF;
         clip = 1'b1;
      end else if (shifted < SAT_MIN) begin
         res  = 16'sh8000;
         clip = 1'b1;
      end
      if (relu_q && res[15]) begin
         res = 16'sh0000;
      end
   end

   // Kernel register file, written once per run during LD_KERNEL.
   // NOTE: the kernel store has no reset; it is always reloaded before use, and leaving reset off keeps it a plain register file.
   always_ff @(posedge CLK) begin
      if (state == LD_KERNEL && xfer_done) begin
         kern[eidx] <= data_o[15:0];
      end
   end

   // Main controller: sequencing, Wishbone request generation, accumulation.
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
      if (rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         sat_flag <= 1'b0;
         stb_i    <= 1'b0;
         cyc_i    <= 1'b0;
         we_i     <= 1'b0;
         sel_i    <= 4'b0000;
         addr_i   <= 32'd0;
         data_i   <= 32'd0;
         relu_q   <= 1'b0;
         eidx     <= '0;
         ki       <= 16'd0;
         kj       <= 16'd0;
         oi       <= 16'd0;
         oj       <= 16'd0;
         acc      <= '0;
      end else begin
         done <= 1'b0;
         // A request leaves the bus on the first edge where it is not stalled.
         if (stb_i && !stall_o) begin
            stb_i <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  relu_q   <= relu_en;
                  sat_flag <= 1'b0;
                  busy     <= 1'b1;
                  eidx     <= '0;
                  ki       <= 16'd0;
                  kj       <= 16'd0;
                  oi       <= 16'd0;
                  oj       <= 16'd0;
                  stb_i    <= 1'b1;
                  cyc_i    <= 1'b1;
                  we_i     <= 1'b0;
                  sel_i    <= 4'b0011;
                  addr_i   <= 32'(KERNEL_BASE);
                  state    <= LD_KERNEL;
               end
            end

            LD_KERNEL: begin
               if (xfer_done) begin
                  stb_i <= 1'b1;
                  cyc_i <= 1'b1;
                  if (e_last) begin
                     eidx   <= '0;
                     acc    <= '0;
                     addr_i <= pix_addr(16'd0, 16'd0);
                     state  <= RD_PIX;
                  end else begin
                     eidx   <= eidx + EW'(1);
                     addr_i <= kaddr_nx;
                  end
               end
            end

            RD_PIX: begin
               if (xfer_done) begin
                  acc   <= acc_sum;
                  stb_i <= 1'b1;
                  cyc_i <= 1'b1;
                  if (e_last) begin
                     eidx   <= '0;
                     ki     <= 16'd0;
                     kj     <= 16'd0;
                     we_i   <= 1'b1;
                     addr_i <= out_addr;
                     data_i <= {{16{res[15]}}, res};
                     if (clip) begin
                        sat_flag <= 1'b1;
                     end
                     state  <= WR_OUT;
                  end else begin
                     eidx   <= eidx + EW'(1);
                     ki     <= ki_nx;
                     kj     <= kj_nx;
                     addr_i <= pix_addr_nx;
                  end
               end
            end

            WR_OUT: begin
               if (xfer_done) begin
                  we_i <= 1'b0;
                  if (oi_last && oj_last) begin
                     stb_i <= 1'b0;
                     cyc_i <= 1'b0;
                     sel_i <= 4'b0000;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= FINISH;
                  end else begin
                     oi     <= oi_nx;
                     oj     <= oj_nx;
                     acc    <= '0;
                     stb_i  <= 1'b1;
                     cyc_i  <= 1'b1;
                     addr_i <= win_addr;
                     state  <= RD_PIX;
                  end
               end
            end

            FINISH: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_conv_kxk_layer.sv
// tb_conv_kxk_layer: directed bench for conv_kxk_layer on a 4x4 map with a
// 3x3 kernel. A behavioural Wishbone slave with a small word memory answers
// the DUT. It can stall the first request of a run and delay write acks, and
// it counts protocol violations. Expected values are hand-computed constants.

module tb_conv_kxk_layer;

   localparam int OUT0 = 118;

   logic        CLK = 1'b0;
   logic        rst, start, relu_en;
   logic        busy, done, sat_flag;
   logic [31:0] data_o;
   logic        stall_o;
   logic        sdram_ack;
   logic        stb_i, we_i, cyc_i;
   logic [3:0]  sel_i;
   logic [31:0] addr_i, data_i;

   logic        slv_ack, stray_ack;
   logic [31:0] mem [0:255];

   // Slave model state.
   logic        pending, p_we, stall_prev, st_we;
   logic [31:0] p_addr, p_data, st_addr;
   int          wait_left, wr_delay, stall_left, stalls_seen, proto_err, done_cnt;

   int          tests = 0;
   int          fails = 0;
   int          cycles;

   assign sdram_ack = slv_ack | stray_ack;

   always #5 CLK = ~CLK;

   conv_kxk_layer #(
      .IMG_W(4), .IMG_H(4), .K(3), .KERNEL_BASE(0), .IMG_BASE(18),
      .OUT_BASE(118), .ACC_W(40), .FRAC(8)
   ) dut (
      .CLK(CLK), .rst(rst), .start(start), .relu_en(relu_en),
      .busy(busy), .done(done), .sat_flag(sat_flag),
      .data_o(data_o), .stall_o(stall_o), .sdram_ack(sdram_ack),
      .stb_i(stb_i), .we_i(we_i), .sel_i(sel_i), .cyc_i(cyc_i),
      .addr_i(addr_i), .data_i(data_i)
   );

   // Wishbone slave, driven on the falling edge, away from the DUT's edge.
   always @(negedge CLK) begin
      slv_ack = 1'b0;
      stall_o = 1'b0;
      if (rst) begin
         pending    = 1'b0;
         stall_prev = 1'b0;
      end else begin
         if (stall_prev && !(stb_i === 1'b1 && addr_i === st_addr && we_i === st_we))
            proto_err++;
         stall_prev = 1'b0;
         if (pending) begin
            if (stb_i !== 1'b0 || cyc_i !== 1'b1) proto_err++;
            if (wait_left == 0) begin
               slv_ack = 1'b1;
               pending = 1'b0;
               if (p_we) mem[p_addr[7:0]] = p_data;
               else      data_o = mem[p_addr[7:0]];
            end else begin
               wait_left--;
            end
         end else if (stb_i === 1'b1) begin
            if (cyc_i !== 1'b1 || sel_i !== 4'b0011) proto_err++;
            if (stall_left > 0) begin
               stall_o    = 1'b1;
               stall_left--;
               stalls_seen++;
               stall_prev = 1'b1;
               st_addr    = addr_i;
               st_we      = we_i;
            end else begin
               pending   = 1'b1;
               wait_left = we_i ? wr_delay : 0;
               p_addr    = addr_i;
               p_we      = we_i;
               p_data    = data_i;
            end
         end
      end
      if (done === 1'b1) done_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic load_kernel(input logic [31:0] centre, input logic [31:0] others);
      for (int i = 0; i < 9; i++) mem[i] = (i == 4) ? centre : others;
   endtask

   task automatic load_image_ramp();
      for (int i = 0; i < 16; i++) mem[18 + i] = 32'(i + 1);
   endtask

   task automatic load_image_const(input logic [31:0] v);
      for (int i = 0; i < 16; i++) mem[18 + i] = v;
   endtask

   task automatic clear_out();
      for (int i = 0; i < 4; i++) mem[OUT0 + i] = 32'hDEADBEEF;
   endtask

   task automatic check_outputs(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                                input logic [31:0] e2, input logic [31:0] e3);
      check({tag, "_out0"}, mem[OUT0 + 0], e0);
      check({tag, "_out1"}, mem[OUT0 + 1], e1);
      check({tag, "_out2"}, mem[OUT0 + 2], e2);
      check({tag, "_out3"}, mem[OUT0 + 3], e3);
   endtask

   // Pulse start and wait (bounded) for done. The start edge counts as edge 1,
   // so n is the number of edges up to and including the one raising done.
   // extra_at >= 0 re-pulses start at that point of the run.
   task automatic run_layer(input logic relu, input int extra_at, output int n);
      done_cnt = 0;
      start    = 1'b1;
      relu_en  = relu;
      @(posedge CLK); #1;
      start   = 1'b0;
      relu_en = 1'b0;
      n       = 1;
      check("busy_after_start", {31'd0, busy}, 32'd1);
      while (done !== 1'b1 && n < 3000) begin
         start = (n == extra_at);
         @(posedge CLK); #1;
         n++;
      end
      start = 1'b0;
      check("done_seen", {31'd0, done}, 32'd1);
      check("busy_low_at_done", {31'd0, busy}, 32'd0);
      @(posedge CLK); #1;
      check("done_single", 32'(done_cnt), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; start = 1'b0; relu_en = 1'b0; stray_ack = 1'b0;
      slv_ack = 1'b0; stall_o = 1'b0; data_o = 32'd0;
      pending = 1'b0; p_we = 1'b0; stall_prev = 1'b0; st_we = 1'b0;
      p_addr = 32'd0; p_data = 32'd0; st_addr = 32'd0;
      wait_left = 0; wr_delay = 0; stall_left = 0; stalls_seen = 0; proto_err = 0; done_cnt = 0;
      for (int i = 0; i < 256; i++) mem[i] = 32'd0;

      // Reset values.
      repeat (3) @(posedge CLK);
      #1;
      check("rst_busy",  {31'd0, busy},     32'd0);
      check("rst_done",  {31'd0, done},     32'd0);
      check("rst_sat",   {31'd0, sat_flag}, 32'd0);
      check("rst_stb",   {31'd0, stb_i},    32'd0);
      check("rst_cyc",   {31'd0, cyc_i},    32'd0);
      check("rst_we",    {31'd0, we_i},     32'd0);
      check("rst_sel",   {28'd0, sel_i},    32'd0);
      check("rst_addr",  addr_i,            32'd0);
      check("rst_data",  data_i,            32'd0);
      rst = 1'b0;
      @(posedge CLK); #1;

      // Identity kernel: each output is the window centre pixel.
      load_kernel(32'd256, 32'd0);
      load_image_ramp();
      clear_out();
      run_layer(1'b0, -1, cycles);
      check("ident_len", 32'(cycles), 32'd99);
      check_outputs("ident", 32'd6, 32'd7, 32'd10, 32'd11);
      check("ident_sat", {31'd0, sat_flag}, 32'd0);
      check("ident_proto", 32'(proto_err), 32'd0);

      // Saturation: 9*32767*256 >> 8 clips to 32767.
      load_kernel(32'd256, 32'd256);
      load_image_const(32'h0000_7FFF);
      clear_out();
      run_layer(1'b0, -1, cycles);
      check_outputs("sat", 32'h0000_7FFF, 32'h0000_7FFF, 32'h0000_7FFF, 32'h0000_7FFF);
      check("sat_flag_set", {31'd0, sat_flag}, 32'd1);
      repeat (2) @(posedge CLK);
      #1;
      check("sat_flag_sticky", {31'd0, sat_flag}, 32'd1);

      // ReLU on: negated centre clamps to zero; this start also clears sat_flag.
      load_kernel(32'hFFFF_FF00, 32'd0);
      load_image_ramp();
      clear_out();
      run_layer(1'b1, -1, cycles);
      check_outputs("relu_on", 32'd0, 32'd0, 32'd0, 32'd0);
      check("relu_sat_cleared", {31'd0, sat_flag}, 32'd0);

      // ReLU off: negative results sign-extended.
      clear_out();
      run_layer(1'b0, -1, cycles);
      check_outputs("relu_off", 32'hFFFF_FFFA, 32'hFFFF_FFF9, 32'hFFFF_FFF6, 32'hFFFF_FFF5);

      // Stall 3 cycles on the first read, delay write acks by 4 cycles.
      load_kernel(32'd256, 32'd0);
      clear_out();
      proto_err   = 0;
      stalls_seen = 0;
      stall_left  = 3;
      wr_delay    = 4;
      run_layer(1'b0, -1, cycles);
      wr_delay = 0;
      check_outputs("stall", 32'd6, 32'd7, 32'd10, 32'd11);
      check("stall_count", 32'(stalls_seen), 32'd3);
      check("stall_proto", 32'(proto_err), 32'd0);
      check("stall_len", 32'(cycles), 32'd118);

      // start while busy is ignored.
      clear_out();
      run_layer(1'b0, 40, cycles);
      check("busy_start_len", 32'(cycles), 32'd99);
      check_outputs("busy_start", 32'd6, 32'd7, 32'd10, 32'd11);

      // Stray ack while idle changes nothing.
      done_cnt  = 0;
      stray_ack = 1'b1;
      @(posedge CLK); #1;
      stray_ack = 1'b0;
      @(posedge CLK); #1;
      check("stray_busy", {31'd0, busy},  32'd0);
      check("stray_stb",  {31'd0, stb_i}, 32'd0);
      check("stray_cyc",  {31'd0, cyc_i}, 32'd0);
      check("stray_done", 32'(done_cnt),  32'd0);

      // Reset in the middle of RD_PIX, then a clean rerun.
      clear_out();
      start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      repeat (25) @(posedge CLK);
      #1;
      check("mid_busy_before_rst", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      @(posedge CLK); #1;
      rst = 1'b0;
      check("mid_rst_stb",  {31'd0, stb_i}, 32'd0);
      check("mid_rst_cyc",  {31'd0, cyc_i}, 32'd0);
      check("mid_rst_busy", {31'd0, busy},  32'd0);
      repeat (3) @(posedge CLK);
      #1;
      check("mid_rst_idle_stb", {31'd0, stb_i}, 32'd0);
      proto_err = 0;
      run_layer(1'b0, -1, cycles);
      check("after_rst_len", 32'(cycles), 32'd99);
      check_outputs("after_rst", 32'd6, 32'd7, 32'd10, 32'd11);
      check("after_rst_proto", 32'(proto_err), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
